// File: rtl/tff_ctrl_pkg.sv
// tff_ctrl_pkg: shared state encoding and default sizing for the ripple-counter sequencer
package tff_ctrl_pkg;

    localparam int DEF_WIDTH     = 3;
    localparam int DEF_SETTLE    = 2;
    localparam int DEF_CLR_TRIES = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLR_RST = 3'd1,
        ST_CLR_CHK = 3'd2,
        ST_RUN     = 3'd3,
        ST_SETTLE  = 3'd4,
        ST_DONE    = 3'd5
    } ctrl_state_t;

endpackage

// File: rtl/tff_counter_ctrl_settle_timer.sv
// tff_settle_timer: loadable down-counter; zero_o marks the last settle cycle
module tff_settle_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] val_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;

    // load on entry, then count down and park at zero
    always_ff @(posedge clk) begin
        if (reset)
            cnt_q <= '0;
        else if (load_i)
            cnt_q <= val_i;
        else if (cnt_q != '0)
            cnt_q <= cnt_q - 1'b1;
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/tff_counter_ctrl.sv
// tff_counter_ctrl: clears, runs, freezes and checks a T-flip-flop ripple counter
module tff_counter_ctrl
    import tff_ctrl_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int SETTLE    = DEF_SETTLE,
    parameter int CLR_TRIES = DEF_CLR_TRIES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] limit,
    input  logic             auto_reload,
    input  logic [WIDTH-1:0] cnt_q,
    output logic [WIDTH-1:0] tff_t,
    output logic             tff_rst,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_count,
    output logic             res_mismatch,
    output logic             res_aborted,
    output logic             clr_err
);

    localparam int TW  = $clog2(SETTLE + 1);
    localparam int TRW = $clog2(CLR_TRIES + 1);

    ctrl_state_t     state_q, state_d;
    logic [TRW-1:0]  tries_q, tries_d;
    logic [WIDTH:0]  shadow_q, shadow_d;
    logic [WIDTH-1:0] limit_q, tff_t_q, res_count_q;
    logic            reload_q, tff_rst_q, busy_q, res_valid_q;
    logic            res_mismatch_q, res_aborted_q, clr_err_q;
    logic            pulse, abort_set, capture, new_run, err_set, accept, settle_done;

    assign accept = (state_q == ST_IDLE) && start;

    tff_settle_timer #(.W(TW)) u_settle (
        .clk    (clk),
        .reset  (reset),
        .load_i (state_d == ST_SETTLE && state_q != ST_SETTLE),
        .val_i  (TW'(SETTLE - 1)),
        .zero_o (settle_done)
    );

    // sequencer next state, retry bookkeeping and shadow count
    always_comb begin
        state_d   = state_q;
        tries_d   = tries_q;
        shadow_d  = shadow_q;
        pulse     = 1'b0;
        abort_set = 1'b0;
        capture   = 1'b0;
        new_run   = 1'b0;
        err_set   = 1'b0;
        case (state_q)
            ST_IDLE: if (start) begin
                state_d  = ST_CLR_RST;
                tries_d  = '0;
                shadow_d = '0;
                new_run  = 1'b1;
            end
            ST_CLR_RST: state_d = ST_CLR_CHK;
            ST_CLR_CHK: if (cnt_q == '0) begin
                state_d = (limit_q == '0) ? ST_SETTLE : ST_RUN;
            end else begin
                tries_d = tries_q + 1'b1;
                err_set = (tries_d == TRW'(CLR_TRIES));
                pulse   = !err_set;
                state_d = err_set ? ST_IDLE : ST_CLR_RST;
            end
            ST_RUN: begin
                shadow_d  = shadow_q + 1'b1;
                abort_set = stop && (shadow_d != {1'b0, limit_q});
                state_d   = (stop || shadow_d == {1'b0, limit_q}) ? ST_SETTLE : ST_RUN;
            end
            ST_SETTLE: if (settle_done) begin
                capture = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: if (res_valid_q && res_ready) begin
                state_d  = reload_q ? ST_CLR_RST : ST_IDLE;
                tries_d  = '0;
                shadow_d = '0;
                new_run  = reload_q;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // state, outputs registered from next state; the Q0 retry toggle lands in the
    // following reset cycle so no output depends combinationally on cnt_q
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            tries_q        <= '0;
            shadow_q       <= '0;
            limit_q        <= '0;
            reload_q       <= 1'b0;
            tff_t_q        <= '0;
            tff_rst_q      <= 1'b0;
            busy_q         <= 1'b0;
            res_valid_q    <= 1'b0;
            res_count_q    <= '0;
            res_mismatch_q <= 1'b0;
            res_aborted_q  <= 1'b0;
            clr_err_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tries_q     <= tries_d;
            shadow_q    <= shadow_d;
            tff_t_q     <= (state_d == ST_RUN) ? '1 : WIDTH'(pulse);
            tff_rst_q   <= (state_d == ST_CLR_RST);
            busy_q      <= (state_d != ST_IDLE);
            res_valid_q <= (state_d == ST_DONE);
            if (accept) begin
                limit_q  <= limit;
                reload_q <= auto_reload;
            end
            if (capture) begin
                res_count_q    <= cnt_q;
                res_mismatch_q <= (cnt_q != shadow_q[WIDTH-1:0]);
            end
            if (new_run)
                res_aborted_q <= 1'b0;
            else if (abort_set)
                res_aborted_q <= 1'b1;
            if (accept)
                clr_err_q <= 1'b0;
            else if (err_set)
                clr_err_q <= 1'b1;
        end
    end

    assign tff_t        = tff_t_q;
    assign tff_rst      = tff_rst_q;
    assign busy         = busy_q;
    assign res_valid    = res_valid_q;
    assign res_count    = res_count_q;
    assign res_mismatch = res_mismatch_q;
    assign res_aborted  = res_aborted_q;
    assign clr_err      = clr_err_q;

endmodule

// File: tb/tb_tff_counter_ctrl.sv
// tb_tff_counter_ctrl: directed scenarios against a behavioural ripple-counter model
module tb_tff_counter_ctrl;

    localparam int ST = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [2:0] limit = '0;
    logic       auto_reload = 1'b0;
    logic [2:0] cnt_q = '0;
    logic [2:0] tff_t;
    logic       tff_rst, busy, res_valid, res_mismatch, res_aborted, clr_err;
    logic       res_ready = 1'b0;
    logic [2:0] res_count;
    logic       stuck = 1'b0;
    int         n_cmp = 0;
    int         n_bad = 0;

    tff_counter_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .stop         (stop),
        .limit        (limit),
        .auto_reload  (auto_reload),
        .cnt_q        (cnt_q),
        .tff_t        (tff_t),
        .tff_rst      (tff_rst),
        .busy         (busy),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_count    (res_count),
        .res_mismatch (res_mismatch),
        .res_aborted  (res_aborted),
        .clr_err      (clr_err)
    );

    always #5 clk = ~clk;

    // counter model: all-ones T counts up, lone T0 toggles Q0, stuck holds 010
    always @(posedge clk) begin
        if (stuck)
            cnt_q <= 3'b010;
        else if (tff_rst)
            cnt_q <= '0;
        else if (&tff_t)
            cnt_q <= cnt_q + 3'd1;
        else if (tff_t[0])
            cnt_q[0] <= ~cnt_q[0];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [2:0] lim, input logic ar);
        start = 1'b1;
        limit = lim;
        auto_reload = ar;
        step();
        start = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 1;
        while (!res_valid && cyc < 100) begin
            step();
            cyc++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        n_cmp++;
        if ({tff_t, tff_rst, busy, res_valid, res_count, res_mismatch, res_aborted, clr_err} !== 13'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b required all zero",
                {tff_t, tff_rst, busy, res_valid, res_count, res_mismatch, res_aborted, clr_err});
        end
    endtask

    task automatic test_clean();
        int cyc;
        res_ready = 1'b1;
        do_start(3'd5, 1'b0);
        n_cmp++;
        if (busy !== 1'b1) begin n_bad++; $display("FAIL clean_busy_rise: got %b required 1", busy); end
        wait_valid(cyc);
        n_cmp++;
        if (cyc != 2 + 5 + ST + 1) begin n_bad++; $display("FAIL clean_latency: got %0d required %0d", cyc, 2 + 5 + ST + 1); end
        n_cmp++;
        if ({res_count, res_mismatch, res_aborted} !== {3'd5, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL clean_result: got count=%0d mm=%b ab=%b required 5 0 0", res_count, res_mismatch, res_aborted);
        end
        step();
        n_cmp++;
        if ({busy, res_valid} !== 2'b00) begin n_bad++; $display("FAIL clean_idle_after: got busy=%b valid=%b required 0 0", busy, res_valid); end
    endtask

    task automatic test_wrap();
        int cyc;
        do_start(3'd7, 1'b0);
        wait_valid(cyc);
        n_cmp++;
        if (cyc != 2 + 7 + ST + 1) begin n_bad++; $display("FAIL wrap7_latency: got %0d required %0d", cyc, 2 + 7 + ST + 1); end
        n_cmp++;
        if ({res_count, res_mismatch} !== {3'd7, 1'b0}) begin n_bad++; $display("FAIL wrap7_result: got count=%0d mm=%b required 7 0", res_count, res_mismatch); end
        step();
        do_start(3'd0, 1'b0);
        wait_valid(cyc);
        n_cmp++;
        if (cyc != 2 + 0 + ST + 1) begin n_bad++; $display("FAIL zero_latency: got %0d required %0d", cyc, 2 + ST + 1); end
        n_cmp++;
        if ({res_count, res_mismatch} !== {3'd0, 1'b0}) begin n_bad++; $display("FAIL zero_result: got count=%0d mm=%b required 0 0", res_count, res_mismatch); end
        step();
    endtask

    task automatic test_abort();
        int cyc;
        do_start(3'd6, 1'b0);
        repeat (4) step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        wait_valid(cyc);
        n_cmp++;
        if ({res_count, res_mismatch, res_aborted} !== {3'd3, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL abort_result: got count=%0d mm=%b ab=%b required 3 0 1", res_count, res_mismatch, res_aborted);
        end
        step();
        do_start(3'd3, 1'b0);
        repeat (4) step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        wait_valid(cyc);
        n_cmp++;
        if ({res_count, res_mismatch, res_aborted} !== {3'd3, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL stop_on_terminal: got count=%0d mm=%b ab=%b required 3 0 0", res_count, res_mismatch, res_aborted);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int cyc;
        res_ready = 1'b0;
        do_start(3'd4, 1'b1);
        wait_valid(cyc);
        n_cmp++;
        if (res_count !== 3'd4) begin n_bad++; $display("FAIL reload_first_count: got %0d required 4", res_count); end
        for (int i = 0; i < 5; i++) begin
            step();
            n_cmp++;
            if ({res_valid, res_count} !== {1'b1, 3'd4}) begin
                n_bad++;
                $display("FAIL backpressure_hold: cycle %0d got valid=%b count=%0d required 1 4", i, res_valid, res_count);
            end
        end
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        n_cmp++;
        if ({res_valid, busy, tff_rst} !== 3'b011) begin
            n_bad++;
            $display("FAIL reload_restart: got valid=%b busy=%b rst=%b required 0 1 1", res_valid, busy, tff_rst);
        end
        wait_valid(cyc);
        n_cmp++;
        if (cyc != 2 + 4 + ST + 1) begin n_bad++; $display("FAIL reload_latency: got %0d required %0d", cyc, 2 + 4 + ST + 1); end
        n_cmp++;
        if ({res_count, res_mismatch} !== {3'd4, 1'b0}) begin n_bad++; $display("FAIL reload_second: got count=%0d mm=%b required 4 0", res_count, res_mismatch); end
        test_reset();
    endtask

    task automatic test_stuck_clear();
        int pulses;
        int cyc;
        res_ready = 1'b1;
        stuck = 1'b1;
        do_start(3'd3, 1'b0);
        pulses = 0;
        for (int k = 0; k < 50; k++) begin
            if (tff_rst) pulses++;
            if (!busy) break;
            step();
        end
        n_cmp++;
        if (pulses != 4) begin n_bad++; $display("FAIL stuck_rst_pulses: got %0d required 4", pulses); end
        n_cmp++;
        if ({clr_err, busy, res_valid} !== 3'b100) begin
            n_bad++;
            $display("FAIL stuck_error: got err=%b busy=%b valid=%b required 1 0 0", clr_err, busy, res_valid);
        end
        stuck = 1'b0;
        step();
        n_cmp++;
        if (clr_err !== 1'b1) begin n_bad++; $display("FAIL clr_err_sticky: got %b required 1", clr_err); end
        do_start(3'd1, 1'b0);
        n_cmp++;
        if (clr_err !== 1'b0) begin n_bad++; $display("FAIL clr_err_cleared: got %b required 0", clr_err); end
        wait_valid(cyc);
        n_cmp++;
        if ({res_count, res_mismatch} !== {3'd1, 1'b0}) begin n_bad++; $display("FAIL recover_result: got count=%0d mm=%b required 1 0", res_count, res_mismatch); end
        step();
    endtask

    task automatic test_midrun_reset();
        int cyc;
        do_start(3'd6, 1'b0);
        repeat (3) step();
        reset = 1'b1;
        step();
        n_cmp++;
        if ({tff_t, tff_rst, busy, res_valid, res_count, res_mismatch, res_aborted, clr_err} !== 13'd0) begin
            n_bad++;
            $display("FAIL midrun_reset_outputs: got %b required all zero",
                {tff_t, tff_rst, busy, res_valid, res_count, res_mismatch, res_aborted, clr_err});
        end
        reset = 1'b0;
        do_start(3'd2, 1'b0);
        wait_valid(cyc);
        n_cmp++;
        if ({res_count, res_mismatch} !== {3'd2, 1'b0}) begin n_bad++; $display("FAIL after_reset_run: got count=%0d mm=%b required 2 0", res_count, res_mismatch); end
        step();
    endtask

    initial begin
        test_reset();
        test_clean();
        test_wrap();
        test_abort();
        test_back_to_back();
        test_stuck_clear();
        test_midrun_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
